msx_bus_initiator: RTL

MSX_BUS_INITIATOR -- requirements
Module: msx_bus_initiator

---
 rtl/msx_bus_initiator.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/msx_bus_initiator.sv
// MSX cartridge bus initiator: turns one request into a SETUP/STROBE/HOLD bus cycle, one request in flight.
// REQ_READY only in IDLE; RSP_VALID pulses on the first HOLD cycle; WAIT_n stretches STROBE up to TIMEOUT.
module msx_bus_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TIMEOUT    = 1023,
  parameter int RST_CYC    = 64
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic        REQ_IO,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  input  logic        SOFT_RST,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_TIMEOUT,
  output logic [15:0] ADDR,
  output logic [7:0]  DIN,
  input  logic [7:0]  DOUT,
  output logic        SLTSL_n,
  output logic        MERQ_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  output logic        CS1_n,
  output logic        CS2_n,
  output logic        CS12_n,
  output logic        M1_n,
  output logic        RFSH_n,
  input  logic        WAIT_n,
  output logic        BUS_RESET_n
);

  typedef enum logic [2:0] {S_BRST, S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [3:0] L_SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] L_STB_LAST   = 4'(STROBE_CYC - 1);
  localparam logic [3:0] L_HOLD_LAST  = 4'(HOLD_CYC - 1);
  localparam logic [9:0] L_TO_LAST    = 10'(TIMEOUT - 1);
  localparam logic [7:0] L_RST_LAST   = 8'(RST_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_rst_cnt, w_rst_cnt_nxt;
  logic [9:0]  r_wcnt, w_wcnt_nxt;
  logic        r_write, r_io, r_timeout, r_srst_pend;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata, r_rdata;
  logic        w_accept, w_done, w_to, w_bus_act, w_stb_done, w_mem_rd;

  assign w_bus_act  = (r_state == S_SETUP) || (r_state == S_STROBE);
  assign w_stb_done = (r_cnt == L_STB_LAST);
  assign w_mem_rd   = !r_io && !r_write;
  assign M1_n        = 1'b1;
  assign RFSH_n      = 1'b1;
  assign RSP_RDATA   = r_rdata;
  assign RSP_TIMEOUT = r_timeout;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rst_cnt_nxt = r_rst_cnt;
    w_wcnt_nxt    = r_wcnt;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    w_to          = 1'b0;
    REQ_READY     = 1'b0;
    RSP_VALID     = 1'b0;
    BUS_RESET_n   = 1'b1;
    ADDR          = 16'h0000;
    DIN           = 8'h00;
    SLTSL_n       = 1'b1;
    MERQ_n        = 1'b1;
    IORQ_n        = 1'b1;
    RD_n          = 1'b1;
    WR_n          = 1'b1;
    CS1_n         = 1'b1;
    CS2_n         = 1'b1;
    CS12_n        = 1'b1;

    if (w_bus_act) begin
      ADDR    = r_addr;
      DIN     = r_write ? r_wdata : 8'h00;
      SLTSL_n = r_io;
      MERQ_n  = r_io;
      IORQ_n  = !r_io;
      if (w_mem_rd) begin
        CS1_n  = !(r_addr[15:14] == 2'b01);
        CS2_n  = !(r_addr[15:14] == 2'b10);
        CS12_n = !(r_addr[15] ^ r_addr[14]);
      end
    end

    case (r_state)
      S_BRST: begin
        BUS_RESET_n = 1'b0;
        if (r_rst_cnt == L_RST_LAST) begin
          w_state_nxt   = S_IDLE;
          w_rst_cnt_nxt = 8'd0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 8'd1;
        end
      end
      S_IDLE: begin
        // A soft reset request withdraws READY so a same-cycle request is never handshaken.
        REQ_READY = !SOFT_RST;
        if (SOFT_RST) begin
          w_state_nxt   = S_BRST;
          w_rst_cnt_nxt = 8'd0;
        end else if (REQ_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_SETUP: begin
        if (r_cnt == L_SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 4'd0;
          w_wcnt_nxt  = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_STROBE: begin
        RD_n = r_write;
        WR_n = !r_write;
        if (!WAIT_n && (r_wcnt == L_TO_LAST)) begin
          w_to        = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 4'd0;
          w_wcnt_nxt  = 10'd0;
        end else if (w_stb_done && WAIT_n) begin
          w_done      = 1'b1;
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 4'd0;
          w_wcnt_nxt  = 10'd0;
        end else begin
          if (!w_stb_done) w_cnt_nxt = r_cnt + 4'd1;
          w_wcnt_nxt = WAIT_n ? 10'd0 : r_wcnt + 10'd1;
        end
      end
      S_HOLD: begin
        ADDR      = r_addr;
        RSP_VALID = (r_cnt == 4'd0);
        if (r_cnt == L_HOLD_LAST) begin
          if (r_srst_pend || SOFT_RST) begin
            w_state_nxt   = S_BRST;
            w_rst_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt   = S_BRST;
        w_rst_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= S_BRST;
      r_cnt     <= 4'd0;
      r_rst_cnt <= 8'd0;
      r_wcnt    <= 10'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_write     <= 1'b0;
      r_io        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
      r_timeout   <= 1'b0;
      r_srst_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= REQ_WRITE;
        r_io    <= REQ_IO;
        r_addr  <= REQ_ADDR;
        r_wdata <= REQ_WDATA;
      end
      if (w_done) begin
        r_timeout <= w_to;
        if (w_to)          r_rdata <= 8'hFF;
        else if (!r_write) r_rdata <= DOUT;
      end
      // Pending only matters while a transaction is in flight; it is consumed on entry to BRST.
      if (w_state_nxt == S_BRST)
        r_srst_pend <= 1'b0;
      else if (SOFT_RST && (w_bus_act || (r_state == S_HOLD)))
        r_srst_pend <= 1'b1;
    end
  end

endmodule
